req_frame_tx: RTL
=================

# req_frame_tx

Downstream consumer of the request FIFO: pops 64-bit request words and emits them as framed beats (sop/eop) to the TX PHY stage. The in-band delimiter word (low byte 8'hEE) is stripped, and the preceding word is marked end-of-packet. The block enforces a maximum request length and an inter-request gap, and keeps request and error counters.

## Interface
- WIDTH, 64: data width; must match the request FIFO.
- MAX_WORDS, 16: maximum payload words per request (range 1..255).
- GAP, 2: idle cycles forced after each eop beat (range 0..15).
- DELIM, 8'hEE: delimiter value, compared against word bits [7:0].
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fifo_empty  in  1  request FIFO empty.
- fifo_r_data  in  WIDTH  FIFO head word (first-word-fall-through, valid when !fifo_empty).
- fifo_rd  out  1  pop FIFO head this cycle; never asserted when fifo_empty.
- tx_data  out  WIDTH  beat data.
- tx_valid  out  1  beat valid.
- tx_sop  out  1  first beat of a request.
- tx_eop  out  1  last beat of a request.
- tx_err  out  1  with tx_eop: request was truncated at MAX_WORDS.
- tx_ready  in  1  downstream accepts the beat when tx_valid & tx_ready.
- req_cnt  out  16  completed requests (eop handshakes), wraps modulo 2^16.
- drop_cnt  out  16  empty requests (delimiter arriving with no payload) plus truncations, wraps.
- busy  out  1  state != IDLE.

## Operation
- Holding register: hold_data, hold_vld, hold_first (sop pending), plus word_cnt (8 bits) and gap_cnt (4 bits).
- States: IDLE, LOAD, STREAM, DRAIN, GAP.
- IDLE: if !fifo_empty, assert fifo_rd.
  - If the head is DELIM: drop it, increment drop_cnt, stay in IDLE.
  - Otherwise: hold_data <= head, hold_first <= 1, word_cnt <= 1, go to STREAM.
- STREAM: tx_data = hold_data, tx_sop = hold_first.
  - tx_valid = !fifo_empty | (word_cnt == MAX_WORDS). Lookahead is required to decide eop.
  - tx_eop = (word_cnt == MAX_WORDS) | (!fifo_empty & head == DELIM).
  - tx_err = (word_cnt == MAX_WORDS) & !(!fifo_empty & head == DELIM).
  - On handshake with !tx_eop: pop the head, hold_data <= head, hold_first <= 0, word_cnt++.
  - On handshake with tx_eop and the head is DELIM: pop the delimiter, req_cnt++, go to GAP (or IDLE if GAP == 0).
  - On handshake with tx_err: no pop, req_cnt++, drop_cnt++, go to DRAIN.
- DRAIN: pop every available word and discard it. When the popped word is DELIM, go to GAP (or IDLE if GAP == 0). tx_valid = 0.
- GAP: gap_cnt counts from GAP down to 1, one per cycle. No pops, tx_valid = 0. Return to IDLE when gap_cnt reaches 1.
- LOAD: reserved encoding; unreachable, and falls to IDLE.
- Beat data is held stable while tx_valid & !tx_ready. The block never deasserts tx_valid without a handshake, except on reset.
- fifo_rd is asserted at most once per cycle and only when !fifo_empty.

## Timing
- Reset (async assert, sync release) sets:
  - state = IDLE;
  - fifo_rd, tx_valid, tx_sop, tx_eop, tx_err, busy = 0;
  - tx_data = 0, req_cnt = 0, drop_cnt = 0;
  - hold_vld = 0, word_cnt = 0, gap_cnt = 0.
- fifo_rd is combinational from state and fifo_empty (and tx_ready in STREAM). The FIFO pointer advances on the same edge.
- Latency: first word present in IDLE at cycle t → tx_valid with tx_sop at t+1, provided the second word is present.
- Throughput: one beat per cycle. A request of N payload words occupies N+1 pop cycles plus GAP idle cycles.
- Single-word request: the sop beat also carries eop.
- FIFO empty mid-request (no DELIM yet): tx_valid drops and the block waits. No timeout.
- MAX_WORDS reached: the beat is emitted without lookahead, with eop=1 and err=1. If the head at that moment is DELIM, the request ends normally (err=0).
- Reset mid-request: the frame is abandoned and the downstream must discard the partial packet. Counters clear.

## Test plan
- Stream words A, B, C, then 0x...EE, with tx_ready held at 1 → three beats: A (sop), B, C (eop). req_cnt = 1. After eop, 2 idle cycles before the next pop.
- A lone DELIM in IDLE → no beat, drop_cnt = 1, busy stays 0.
- 20 payload words then DELIM, MAX_WORDS = 16 → 16 beats; beat 16 has eop=1 and err=1. Words 17–20 and the DELIM are drained. req_cnt = 1, drop_cnt = 1.
- Single word X, then DELIM, with tx_ready toggling 0/1 → exactly one beat X with sop=1 and eop=1, data stable while stalled. fifo_rd fires exactly twice.
- FIFO empties after word B, DELIM arrives 5 cycles later → A is emitted, then tx_valid=0 for the stall, then B with eop. No pop while fifo_empty.
- reset_n asserted low during beat 2 of a 4-word request → all outputs 0 immediately (asynchronously). After release, the next request starts cleanly with sop.

Source files
------------

// File: rtl/req_frame_tx.sv
// req_frame_tx: pops request words from a first-word-fall-through FIFO and
// emits them as sop/eop framed beats. The delimiter word is stripped and marks
// the previous word as the last beat; over-long requests are truncated, the
// remainder drained, and an idle gap is enforced after each request.
module req_frame_tx #(
  parameter int         WIDTH     = 64,
  parameter int         MAX_WORDS = 16,
  parameter int         GAP       = 2,
  parameter logic [7:0] DELIM     = 8'hEE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_r_data,
  output logic             fifo_rd,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  output logic             tx_sop,
  output logic             tx_eop,
  output logic             tx_err,
  input  logic             tx_ready,
  output logic [15:0]      req_cnt,
  output logic [15:0]      drop_cnt,
  output logic             busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_GAP    = 3'd4
  } state_t;

  // With no gap configured a finished request goes straight back to IDLE.
  localparam state_t AFTER_EOP = (GAP == 0) ? ST_IDLE : ST_GAP;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] hold_data_reg;
  logic             hold_vld_reg;
  logic             hold_first_reg;
  logic [7:0]       word_cnt_reg;
  logic [3:0]       gap_cnt_reg;
  logic [15:0]      req_cnt_reg;
  logic [15:0]      drop_cnt_reg;

  logic head_delim;
  logic at_max;
  logic stream_valid;
  logic eop_now;
  logic err_now;
  logic handshake;
  logic load_word;
  logic drop_empty;
  logic adv;
  logic end_ok;
  logic end_err;
  logic drain_end;

  // The head is only meaningful while the FIFO is non-empty.
  assign head_delim   = !fifo_empty && (fifo_r_data[7:0] == DELIM);
  assign at_max       = (word_cnt_reg == 8'(MAX_WORDS));
  // A held word can only go out once we know whether it is the last one:
  // either the next word is visible, or the length limit forces the end.
  assign stream_valid = hold_vld_reg && (!fifo_empty || at_max);
  assign eop_now      = at_max || head_delim;
  assign err_now      = at_max && !head_delim;
  assign handshake    = (state_reg == ST_STREAM) && stream_valid && tx_ready;

  assign load_word  = (state_reg == ST_IDLE) && !fifo_empty && !head_delim;
  assign drop_empty = (state_reg == ST_IDLE) && head_delim;
  assign adv        = handshake && !eop_now;
  assign end_ok     = handshake && head_delim;
  assign end_err    = handshake && err_now;
  assign drain_end  = (state_reg == ST_DRAIN) && head_delim;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (load_word) state_next = ST_STREAM;
      ST_STREAM: begin
        if (end_ok)       state_next = AFTER_EOP;
        else if (end_err) state_next = ST_DRAIN;
      end
      ST_DRAIN:  if (drain_end) state_next = AFTER_EOP;
      ST_GAP:    if (gap_cnt_reg <= 4'd1) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output decode; the pop strobe is held off while reset is asserted.
  always_comb begin
    fifo_rd  = 1'b0;
    tx_data  = '0;
    tx_valid = 1'b0;
    tx_sop   = 1'b0;
    tx_eop   = 1'b0;
    tx_err   = 1'b0;
    case (state_reg)
      ST_IDLE:   fifo_rd = !fifo_empty;
      ST_STREAM: begin
        // Truncation leaves the current head in the FIFO for DRAIN to discard.
        fifo_rd  = handshake && !err_now;
        tx_data  = hold_data_reg;
        tx_valid = stream_valid;
        tx_sop   = stream_valid && hold_first_reg;
        tx_eop   = stream_valid && eop_now;
        tx_err   = stream_valid && err_now;
      end
      ST_DRAIN:  fifo_rd = !fifo_empty;
      default:   fifo_rd = 1'b0;
    endcase
    fifo_rd = fifo_rd && reset_n;
  end

  assign busy     = (state_reg != ST_IDLE);
  assign req_cnt  = req_cnt_reg;
  assign drop_cnt = drop_cnt_reg;

  // Holding register, word/gap counters and statistics.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_data_reg  <= '0;
      hold_vld_reg   <= 1'b0;
      hold_first_reg <= 1'b0;
      word_cnt_reg   <= 8'd0;
      gap_cnt_reg    <= 4'd0;
      req_cnt_reg    <= 16'd0;
      drop_cnt_reg   <= 16'd0;
    end else begin
      if (load_word) begin
        hold_data_reg  <= fifo_r_data;
        hold_vld_reg   <= 1'b1;
        hold_first_reg <= 1'b1;
        word_cnt_reg   <= 8'd1;
      end else if (adv) begin
        hold_data_reg  <= fifo_r_data;
        hold_first_reg <= 1'b0;
        word_cnt_reg   <= word_cnt_reg + 8'd1;
      end else if (end_ok || end_err) begin
        hold_vld_reg   <= 1'b0;
        hold_first_reg <= 1'b0;
      end

      if (end_ok || drain_end)
        gap_cnt_reg <= 4'(GAP);
      else if ((state_reg == ST_GAP) && (gap_cnt_reg != 4'd0))
        gap_cnt_reg <= gap_cnt_reg - 4'd1;

      if (end_ok || end_err)
        req_cnt_reg <= req_cnt_reg + 16'd1;
      if (drop_empty || end_err)
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

endmodule
